// File: rtl/timer0_ctrl.sv
// timer0_ctrl - 8051 timer/counter 0: TL0/TH0 counting in TMOD modes 0-3, TR0/TF0 ownership.
// Machine-cycle prescaler and synchronised T0 falling-edge detector supply the count events.
module timer0_ctrl #(
  parameter int TICK_DIV = 12
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic [7:0] addr,
  input  logic       wr_en,
  input  logic       wr_bit_en,
  input  logic       bit_in,
  input  logic [3:0] tmod_lo,
  input  logic       tr1,
  input  logic       int0_pin,
  input  logic       t0_pin,
  input  logic       int_ack0,
  output logic [7:0] tl0_data,
  output logic [7:0] th0_data,
  output logic       tr0,
  output logic       tf0,
  output logic       tf1_set
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [7:0] ADDR_TCON = 8'h88;
  localparam logic [7:0] ADDR_TL0  = 8'h8A;
  localparam logic [7:0] ADDR_TH0  = 8'h8C;
  localparam logic [7:0] BIT_TR0   = 8'h8C;
  localparam logic [7:0] BIT_TF0   = 8'h8D;

  logic [PW-1:0] pre;
  logic          tick;
  logic          t0_s1, t0_s2, t0_last;
  logic          t0_evt;
  logic          gate, ct;
  logic [1:0]    mode;
  logic          run0, inc0;
  logic          byte_wr, bit_wr;
  logic          tl_we, th_we;
  logic [7:0]    tl_cnt, th_cnt;
  logic          ovf0, ovf1;

  assign tick = (pre == PW'(TICK_DIV - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) pre <= '0;
    else        pre <= tick ? '0 : pre + 1'b1;
  end

  // T0 is sampled once per machine cycle, so one event needs a high tick then a low tick.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      t0_s1   <= 1'b1;
      t0_s2   <= 1'b1;
      t0_last <= 1'b1;
    end else begin
      t0_s1 <= t0_pin;
      t0_s2 <= t0_s1;
      if (tick) t0_last <= t0_s2;
    end
  end

  assign t0_evt = tick & t0_last & ~t0_s2;

  assign gate = tmod_lo[3];
  assign ct   = tmod_lo[2];
  assign mode = tmod_lo[1:0];
  assign run0 = tr0 & (~gate | int0_pin);
  assign inc0 = run0 & (ct ? t0_evt : tick);

  assign byte_wr = wr_en & ~wr_bit_en;
  assign bit_wr  = wr_en & wr_bit_en;
  assign tl_we   = byte_wr & (addr == ADDR_TL0);
  assign th_we   = byte_wr & (addr == ADDR_TH0);

  // A byte written this edge neither carries into its partner nor reports overflow.
  always_comb begin
    tl_cnt = tl0_data;
    th_cnt = th0_data;
    ovf0   = 1'b0;
    ovf1   = 1'b0;
    case (mode)
      2'd0: if (inc0) begin
        tl_cnt = {tl0_data[7:5], tl0_data[4:0] + 5'd1};
        if (tl0_data[4:0] == 5'h1F && !tl_we) begin
          th_cnt = th0_data + 8'd1;
          ovf0   = (th0_data == 8'hFF) & ~th_we;
        end
      end
      2'd1: if (inc0) begin
        tl_cnt = tl0_data + 8'd1;
        if (tl0_data == 8'hFF && !tl_we) begin
          th_cnt = th0_data + 8'd1;
          ovf0   = (th0_data == 8'hFF) & ~th_we;
        end
      end
      2'd2: if (inc0) begin
        if (tl0_data == 8'hFF) begin
          tl_cnt = th0_data;
          ovf0   = ~tl_we;
        end else begin
          tl_cnt = tl0_data + 8'd1;
        end
      end
      2'd3: begin
        if (inc0) begin
          tl_cnt = tl0_data + 8'd1;
          ovf0   = (tl0_data == 8'hFF) & ~tl_we;
        end
        if (tick && tr1) begin
          th_cnt = th0_data + 8'd1;
          ovf1   = (th0_data == 8'hFF) & ~th_we;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tl0_data <= 8'h00;
      th0_data <= 8'h00;
      tr0      <= 1'b0;
      tf0      <= 1'b0;
      tf1_set  <= 1'b0;
    end else begin
      tl0_data <= tl_we ? data_in : tl_cnt;
      th0_data <= th_we ? data_in : th_cnt;
      tf1_set  <= ovf1;

      if (byte_wr && addr == ADDR_TCON)   tr0 <= data_in[4];
      else if (bit_wr && addr == BIT_TR0) tr0 <= bit_in;

      // Hardware overflow outranks both software clear and interrupt acknowledge.
      if (ovf0)                           tf0 <= 1'b1;
      else if (byte_wr && addr == ADDR_TCON) tf0 <= data_in[5];
      else if (bit_wr && addr == BIT_TF0) tf0 <= bit_in;
      else if (int_ack0)                  tf0 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_timer0_ctrl.sv
// tb/tb_timer0_ctrl.sv - directed self-checking bench for timer0_ctrl.
module tb_timer0_ctrl;

  localparam int TICK_DIV = 12;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] addr = '0;
  logic       wr_en = 1'b0;
  logic       wr_bit_en = 1'b0;
  logic       bit_in = 1'b0;
  logic [3:0] tmod_lo = '0;
  logic       tr1 = 1'b0;
  logic       int0_pin = 1'b0;
  logic       t0_pin = 1'b1;
  logic       int_ack0 = 1'b0;
  logic [7:0] tl0_data, th0_data;
  logic       tr0, tf0, tf1_set;

  int tests = 0;
  int fails = 0;
  int ph;

  timer0_ctrl #(.TICK_DIV(TICK_DIV)) dut (
    .clock(clock), .reset(reset), .data_in(data_in), .addr(addr),
    .wr_en(wr_en), .wr_bit_en(wr_bit_en), .bit_in(bit_in), .tmod_lo(tmod_lo),
    .tr1(tr1), .int0_pin(int0_pin), .t0_pin(t0_pin), .int_ack0(int_ack0),
    .tl0_data(tl0_data), .th0_data(th0_data), .tr0(tr0), .tf0(tf0), .tf1_set(tf1_set)
  );

  always #5 clock = ~clock;

  // Machine-cycle phase reference: the edge taken while ph==TICK_DIV-1 is a tick edge.
  always @(posedge clock or negedge reset) begin
    if (!reset) ph <= 0;
    else        ph <= (ph == TICK_DIV - 1) ? 0 : ph + 1;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic to_tick_pre();
    while (ph != TICK_DIV - 1) step();
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      to_tick_pre();
      step();
    end
  endtask

  task automatic sfr_wr(input logic [7:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_bit_en = 1'b0; addr = a; data_in = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic sfr_bit(input logic [7:0] a, input logic b);
    wr_en = 1'b1; wr_bit_en = 1'b1; addr = a; bit_in = b;
    step();
    wr_en = 1'b0; wr_bit_en = 1'b0;
  endtask

  task automatic t0_pulse();
    t0_pin = 1'b0;
    repeat (3 * TICK_DIV) step();
    t0_pin = 1'b1;
    repeat (3 * TICK_DIV) step();
  endtask

  initial begin
    repeat (2) step();
    check("rst_tl0", {8'h0, tl0_data}, 16'h0000);
    check("rst_th0", {8'h0, th0_data}, 16'h0000);
    check("rst_tr0", {15'h0, tr0}, 16'h0000);
    check("rst_tf0", {15'h0, tf0}, 16'h0000);
    check("rst_tf1_set", {15'h0, tf1_set}, 16'h0000);
    reset = 1'b1;
    step();

    // Mode 1 overflow and acknowledge
    tmod_lo = 4'b0001;
    sfr_wr(8'h8A, 8'hFE);
    sfr_wr(8'h8C, 8'hFF);
    sfr_wr(8'h88, 8'h10);
    check("m1_tr0_set", {15'h0, tr0}, 16'h0001);
    tick_n(1);
    check("m1_first_tick", {th0_data, tl0_data}, 16'hFFFF);
    check("m1_no_ovf_yet", {15'h0, tf0}, 16'h0000);
    tick_n(1);
    check("m1_wrap", {th0_data, tl0_data}, 16'h0000);
    check("m1_tf0", {15'h0, tf0}, 16'h0001);
    int_ack0 = 1'b1;
    step();
    int_ack0 = 1'b0;
    check("m1_ack_clear", {15'h0, tf0}, 16'h0000);
    sfr_wr(8'h88, 8'h00);

    // Mode 2 auto-reload
    tmod_lo = 4'b0010;
    sfr_wr(8'h8C, 8'h9C);
    sfr_wr(8'h8A, 8'hFE);
    sfr_wr(8'h88, 8'h10);
    tick_n(2);
    check("m2_reload", {th0_data, tl0_data}, 16'h9C9C);
    check("m2_tf0", {15'h0, tf0}, 16'h0001);
    int_ack0 = 1'b1;
    step();
    int_ack0 = 1'b0;
    tick_n(99);
    check("m2_99_ticks", {8'h0, tl0_data}, 16'h00FF);
    check("m2_no_ovf_99", {15'h0, tf0}, 16'h0000);
    tick_n(1);
    check("m2_100th_tick", {th0_data, tl0_data}, 16'h9C9C);
    check("m2_tf0_again", {15'h0, tf0}, 16'h0001);
    sfr_wr(8'h88, 8'h00);

    // Mode 0, 13-bit wrap preserves TL0[7:5]
    tmod_lo = 4'b0000;
    sfr_wr(8'h8A, 8'hFF);
    sfr_wr(8'h8C, 8'hFF);
    sfr_wr(8'h88, 8'h10);
    tick_n(1);
    check("m0_wrap", {th0_data, tl0_data}, 16'h00E0);
    check("m0_tf0", {15'h0, tf0}, 16'h0001);
    sfr_wr(8'h88, 8'h00);

    // Gated external counting
    tmod_lo = 4'b1101;
    sfr_wr(8'h8A, 8'h10);
    sfr_wr(8'h8C, 8'h00);
    int0_pin = 1'b0;
    sfr_wr(8'h88, 8'h10);
    repeat (3) t0_pulse();
    check("gate_blocked", {th0_data, tl0_data}, 16'h0010);
    int0_pin = 1'b1;
    repeat (3) t0_pulse();
    check("gate_open_3_edges", {th0_data, tl0_data}, 16'h0013);
    sfr_wr(8'h88, 8'h00);
    int0_pin = 1'b0;

    // Mode 3, TH0 driven by TR1 with TR0 off
    tmod_lo = 4'b0011;
    sfr_wr(8'h8A, 8'h42);
    sfr_wr(8'h8C, 8'hFF);
    to_tick_pre();
    tr1 = 1'b1;
    step();
    tr1 = 1'b0;
    check("m3_th0_wrap", {8'h0, th0_data}, 16'h0000);
    check("m3_tf1_set", {15'h0, tf1_set}, 16'h0001);
    check("m3_tl0_frozen", {8'h0, tl0_data}, 16'h0042);
    check("m3_tf0_untouched", {15'h0, tf0}, 16'h0000);
    step();
    check("m3_tf1_set_pulse", {15'h0, tf1_set}, 16'h0000);

    // Write priority on counting edges
    tmod_lo = 4'b0001;
    sfr_wr(8'h8A, 8'h20);
    sfr_wr(8'h8C, 8'h00);
    sfr_wr(8'h88, 8'h10);
    to_tick_pre();
    sfr_wr(8'h8A, 8'h55);
    check("tl0_write_wins", {th0_data, tl0_data}, 16'h0055);
    sfr_wr(8'h88, 8'h00);
    sfr_wr(8'h8A, 8'hFF);
    sfr_wr(8'h8C, 8'h10);
    sfr_wr(8'h88, 8'h10);
    to_tick_pre();
    sfr_wr(8'h8C, 8'h77);
    check("th0_write_no_carry", {th0_data, tl0_data}, 16'h7700);
    check("th0_write_no_ovf", {15'h0, tf0}, 16'h0000);
    sfr_wr(8'h88, 8'h00);
    sfr_wr(8'h8A, 8'hFF);
    sfr_wr(8'h8C, 8'hFF);
    sfr_wr(8'h88, 8'h10);
    to_tick_pre();
    sfr_bit(8'h8D, 1'b0);
    check("hw_set_beats_clear", {15'h0, tf0}, 16'h0001);
    check("ovf_wrap_bitwr", {th0_data, tl0_data}, 16'h0000);
    tick_n(1);
    check("counting_before_reset", {th0_data, tl0_data}, 16'h0001);

    // Asynchronous reset mid-count
    reset = 1'b0;
    #1;
    check("async_rst_tl0", {8'h0, tl0_data}, 16'h0000);
    check("async_rst_th0", {8'h0, th0_data}, 16'h0000);
    check("async_rst_tr0", {15'h0, tr0}, 16'h0000);
    check("async_rst_tf0", {15'h0, tf0}, 16'h0000);
    step();
    reset = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
